wr_commit: RTL and testbench

WR_COMMIT -- requirements
Module: wr_commit

---
 rtl/wr_commit_pkg.sv | 30 +++
 rtl/wr_cache_seq.sv | 69 ++++++
 rtl/wr_commit.sv | 187 ++++++++++++++++++
 tb/tb_wr_commit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_commit_pkg.sv
// wr_commit_pkg: shared types and constants for the WR-stage commit logic.
// Holds the commit FSM state encoding, exception-info field offsets,
// cache-op codes and a wrapping pc+4 helper.
package wr_commit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CREQ  = 2'd1,
    ST_CWAIT = 2'd2,
    ST_FLUSH = 2'd3
  } wr_state_t;

  // Exception info layout: bit0 = valid, then the 5-bit excode.
  localparam int EX_VALID_BIT = 0;
  localparam int EX_CODE_LSB  = 1;
  localparam int EX_CODE_W    = 5;

  // Cache operation codes; zero means the instruction carries no cache op.
  localparam int              CACHE_OP_W           = 5;
  localparam logic [4:0]      CACHE_OP_NONE        = 5'h00;
  localparam logic [4:0]      CACHE_OP_I_INDEX_INV = 5'h01;
  localparam logic [4:0]      CACHE_OP_D_INDEX_WB  = 5'h02;
  localparam logic [4:0]      CACHE_OP_D_HIT_INV   = 5'h03;

  // Sequential next-pc; the 32-bit add wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/wr_cache_seq.sv
// wr_cache_seq: drives the cache request/ack/done handshake for a cache
// instruction committed at WR. Latches op, address, pc and the refetch flag
// on start, raises cache_req until ack, then waits for done. Done is only
// looked at once the ack has moved the sequencer into CWAIT.
module wr_cache_seq
  import wr_commit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CACHE_OP_W-1:0] op,
  input  logic [31:0]           addr,
  input  logic [31:0]           pc,
  input  logic                  crefetch,
  input  logic                  cache_ack,
  input  logic                  cache_done,
  output wr_state_t             state,
  output logic                  cache_req,
  output logic [CACHE_OP_W-1:0] cache_req_op,
  output logic [31:0]           cache_req_addr,
  output logic                  finish,
  output logic                  refetch,
  output logic [31:0]           latched_pc
);

  // Done observed while waiting: the commit FSM retires the op this edge.
  assign finish = (state == ST_CWAIT) && cache_done;

  // Handshake sequencer: IDLE -> CREQ (until ack) -> CWAIT (until done).
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cache_req      <= 1'b0;
      cache_req_op   <= CACHE_OP_NONE;
      cache_req_addr <= 32'd0;
      refetch        <= 1'b0;
      latched_pc     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_CREQ;
            cache_req      <= 1'b1;
            cache_req_op   <= op;
            cache_req_addr <= addr;
            refetch        <= crefetch;
            latched_pc     <= pc;
          end
        end
        ST_CREQ: begin
          if (cache_ack) begin
            state     <= ST_CWAIT;
            cache_req <= 1'b0;
          end
        end
        ST_CWAIT: begin
          if (cache_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cache_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wr_commit.sv
// wr_commit: WR-stage commit unit. Retires the WR instruction into the
// register file / CP0, raises exceptions, runs cache instructions through
// wr_cache_seq and requests pipeline refetch. All outputs are registered.
// Optional macro WR_COMMIT_TRACE_EN adds debug_wb_* commit trace outputs.
module wr_commit
  import wr_commit_pkg::*;
#(
  parameter int EX_INFO_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [31:0]          wr_pc,
  input  logic [31:0]          wr_rf_data,
  input  logic [31:0]          wr_badvaddr,
  input  logic [31:0]          wr_cache_paddr,
  input  logic [4:0]           wr_write_reg,
  input  logic [3:0]           wr_reg_write_en,
  input  logic                 wr_cp0_write_en,
  input  logic [7:0]           wr_cp0_write_reg,
  input  logic [EX_INFO_W-1:0] wr_exception_info,
  input  logic                 wr_is_branch,
  input  logic                 wr_inst_refetch,
  input  logic                 wr_crefetch,
  input  logic [4:0]           wr_cache_op,
  output logic [3:0]           rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 cp0_we,
  output logic [7:0]           cp0_waddr,
  output logic [31:0]          cp0_wdata,
  output logic                 ex_commit,
  output logic [4:0]           ex_code,
  output logic [31:0]          ex_epc,
  output logic                 ex_bd,
  output logic [31:0]          ex_badvaddr,
  output logic                 cache_req,
  output logic [4:0]           cache_req_op,
  output logic [31:0]          cache_req_addr,
  input  logic                 cache_ack,
  input  logic                 cache_done,
  output logic                 wr_hold,
  output logic                 pipe_flush,
  output logic [31:0]          refetch_pc
`ifdef WR_COMMIT_TRACE_EN
  ,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
`endif
);

  wr_state_t   state;
  wr_state_t   seq_state;
  logic        flush_reg;
  logic        seq_finish;
  logic        seq_refetch;
  logic [31:0] seq_pc;
  logic        ex_valid;
  logic        has_cop;
  logic        start;
  logic        plain_commit;
  logic [3:0]  rf_we_eff;

  assign ex_valid     = wr_exception_info[EX_VALID_BIT];
  assign has_cop      = (wr_cache_op != CACHE_OP_NONE);
  // FLUSH is a one-cycle tail after a refetching cache op; otherwise the
  // sequencer's state is the commit state.
  assign state        = flush_reg ? ST_FLUSH : seq_state;
  assign start        = (state == ST_IDLE) && wr_valid && !ex_valid && has_cop;
  assign plain_commit = (state == ST_IDLE) && wr_valid && !ex_valid && !has_cop;
  // Register 0 is hard-wired; never strobe a write to it.
  assign rf_we_eff    = (wr_write_reg == 5'd0) ? 4'd0 : wr_reg_write_en;

  wr_cache_seq u_cache_seq (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .op             (wr_cache_op),
    .addr           (wr_cache_paddr),
    .pc             (wr_pc),
    .crefetch       (wr_crefetch),
    .cache_ack      (cache_ack),
    .cache_done     (cache_done),
    .state          (seq_state),
    .cache_req      (cache_req),
    .cache_req_op   (cache_req_op),
    .cache_req_addr (cache_req_addr),
    .finish         (seq_finish),
    .refetch        (seq_refetch),
    .latched_pc     (seq_pc)
  );

  // Commit FSM: strobes default low each cycle, payloads hold until rewritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_reg   <= 1'b0;
      rf_we       <= 4'd0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'd0;
      cp0_we      <= 1'b0;
      cp0_waddr   <= 8'd0;
      cp0_wdata   <= 32'd0;
      ex_commit   <= 1'b0;
      ex_code     <= 5'd0;
      ex_epc      <= 32'd0;
      ex_bd       <= 1'b0;
      ex_badvaddr <= 32'd0;
      wr_hold     <= 1'b0;
      pipe_flush  <= 1'b0;
      refetch_pc  <= 32'd0;
    end else begin
      rf_we      <= 4'd0;
      cp0_we     <= 1'b0;
      ex_commit  <= 1'b0;
      pipe_flush <= 1'b0;
      wr_hold    <= 1'b0;
      flush_reg  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_valid) begin
            if (ex_valid) begin
              ex_commit   <= 1'b1;
              ex_code     <= wr_exception_info[EX_CODE_LSB +: EX_CODE_W];
              ex_epc      <= wr_is_branch ? (wr_pc - 32'd4) : wr_pc;
              ex_bd       <= wr_is_branch;
              ex_badvaddr <= wr_badvaddr;
              pipe_flush  <= 1'b1;
            end else if (has_cop) begin
              wr_hold <= 1'b1;
            end else begin
              rf_we     <= rf_we_eff;
              rf_waddr  <= wr_write_reg;
              rf_wdata  <= wr_rf_data;
              cp0_we    <= wr_cp0_write_en;
              cp0_waddr <= wr_cp0_write_reg;
              cp0_wdata <= wr_rf_data;
              if (wr_inst_refetch) begin
                pipe_flush <= 1'b1;
                refetch_pc <= pc_plus4(wr_pc);
              end
            end
          end
        end
        ST_CREQ: begin
          wr_hold <= 1'b1;
        end
        ST_CWAIT: begin
          if (seq_finish) begin
            if (seq_refetch) begin
              flush_reg  <= 1'b1;
              pipe_flush <= 1'b1;
              refetch_pc <= pc_plus4(seq_pc);
            end
          end else begin
            wr_hold <= 1'b1;
          end
        end
        default: begin
          // FLUSH: single cycle, the WR contents are discarded.
        end
      endcase
    end
  end

`ifdef WR_COMMIT_TRACE_EN
  // Commit trace: mirrors the register-file port alongside the retiring pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      debug_wb_pc       <= 32'd0;
      debug_wb_rf_wen   <= 4'd0;
      debug_wb_rf_wnum  <= 5'd0;
      debug_wb_rf_wdata <= 32'd0;
    end else begin
      debug_wb_rf_wen <= 4'd0;
      if (plain_commit) begin
        debug_wb_pc       <= wr_pc;
        debug_wb_rf_wen   <= rf_we_eff;
        debug_wb_rf_wnum  <= wr_write_reg;
        debug_wb_rf_wdata <= wr_rf_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wr_commit.sv
// tb_wr_commit: scoreboard bench for wr_commit. Expected output images are
// pushed when a WR instruction is driven and popped when the result appears.
module tb_wr_commit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_pc = '0, wr_rf_data = '0, wr_badvaddr = '0, wr_cache_paddr = '0;
  logic [4:0]  wr_write_reg = '0;
  logic [3:0]  wr_reg_write_en = '0;
  logic        wr_cp0_write_en = 1'b0;
  logic [7:0]  wr_cp0_write_reg = '0;
  logic [5:0]  wr_exception_info = '0;
  logic        wr_is_branch = 1'b0, wr_inst_refetch = 1'b0, wr_crefetch = 1'b0;
  logic [4:0]  wr_cache_op = '0;
  logic        cache_ack = 1'b0, cache_done = 1'b0;

  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cp0_we;
  logic [7:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        ex_commit;
  logic [4:0]  ex_code;
  logic [31:0] ex_epc;
  logic        ex_bd;
  logic [31:0] ex_badvaddr;
  logic        cache_req;
  logic [4:0]  cache_req_op;
  logic [31:0] cache_req_addr;
  logic        wr_hold, pipe_flush;
  logic [31:0] refetch_pc;

  int checks = 0;
  int failures = 0;

  wr_commit #(.EX_INFO_W(6)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_pc(wr_pc),
    .wr_rf_data(wr_rf_data), .wr_badvaddr(wr_badvaddr), .wr_cache_paddr(wr_cache_paddr),
    .wr_write_reg(wr_write_reg), .wr_reg_write_en(wr_reg_write_en),
    .wr_cp0_write_en(wr_cp0_write_en), .wr_cp0_write_reg(wr_cp0_write_reg),
    .wr_exception_info(wr_exception_info), .wr_is_branch(wr_is_branch),
    .wr_inst_refetch(wr_inst_refetch), .wr_crefetch(wr_crefetch), .wr_cache_op(wr_cache_op),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .ex_commit(ex_commit), .ex_code(ex_code), .ex_epc(ex_epc), .ex_bd(ex_bd),
    .ex_badvaddr(ex_badvaddr), .cache_req(cache_req), .cache_req_op(cache_req_op),
    .cache_req_addr(cache_req_addr), .cache_ack(cache_ack), .cache_done(cache_done),
    .wr_hold(wr_hold), .pipe_flush(pipe_flush), .refetch_pc(refetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        cp0_we;
    logic [7:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        ex_commit;
    logic [4:0]  ex_code;
    logic [31:0] ex_epc;
    logic        ex_bd;
    logic [31:0] ex_badvaddr;
    logic        pipe_flush;
    logic [31:0] refetch_pc;
    logic        wr_hold;
    logic        cache_req;
  } obs_t;

  obs_t exp_q[$];
  obs_t model = '0;

  function automatic obs_t capture();
    obs_t o;
    o.rf_we = rf_we;           o.rf_waddr = rf_waddr;     o.rf_wdata = rf_wdata;
    o.cp0_we = cp0_we;         o.cp0_waddr = cp0_waddr;   o.cp0_wdata = cp0_wdata;
    o.ex_commit = ex_commit;   o.ex_code = ex_code;       o.ex_epc = ex_epc;
    o.ex_bd = ex_bd;           o.ex_badvaddr = ex_badvaddr;
    o.pipe_flush = pipe_flush; o.refetch_pc = refetch_pc;
    o.wr_hold = wr_hold;       o.cache_req = cache_req;
    return o;
  endfunction

  function automatic obs_t clear_strobes(input obs_t o);
    obs_t r = o;
    r.rf_we = 4'd0; r.cp0_we = 1'b0; r.ex_commit = 1'b0;
    r.pipe_flush = 1'b0; r.wr_hold = 1'b0; r.cache_req = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one live WR instruction and queue the output image it should produce.
  task automatic drive_wr(input logic [31:0] pc, input logic [4:0] wreg, input logic [3:0] en,
                          input logic [31:0] data, input logic c0en, input logic [7:0] c0reg,
                          input logic [5:0] exinfo, input logic br, input logic irf,
                          input logic [4:0] cop, input logic [31:0] paddr, input logic crf,
                          input logic [31:0] badv);
    wr_valid = 1'b1;          wr_pc = pc;            wr_write_reg = wreg;
    wr_reg_write_en = en;     wr_rf_data = data;     wr_cp0_write_en = c0en;
    wr_cp0_write_reg = c0reg; wr_exception_info = exinfo;
    wr_is_branch = br;        wr_inst_refetch = irf; wr_cache_op = cop;
    wr_cache_paddr = paddr;   wr_crefetch = crf;     wr_badvaddr = badv;
    model = clear_strobes(model);
    if (exinfo[0]) begin
      model.ex_commit = 1'b1;
      model.ex_code = exinfo[5:1];
      model.ex_epc = br ? pc - 32'd4 : pc;
      model.ex_bd = br;
      model.ex_badvaddr = badv;
      model.pipe_flush = 1'b1;
    end else if (cop != 5'd0) begin
      model.wr_hold = 1'b1;
      model.cache_req = 1'b1;
    end else begin
      model.rf_we = (wreg == 5'd0) ? 4'd0 : en;
      model.rf_waddr = wreg;
      model.rf_wdata = data;
      model.cp0_we = c0en;
      model.cp0_waddr = c0reg;
      model.cp0_wdata = data;
      if (irf) begin
        model.pipe_flush = 1'b1;
        model.refetch_pc = pc + 32'd4;
      end
    end
    exp_q.push_back(model);
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    repeat (2) tick();
    got = capture();
    checks++;
    if (got !== '0 || cache_req_op !== 5'd0 || cache_req_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got=%h op=%h addr=%h want all zero", got, cache_req_op, cache_req_addr);
    end
    reset = 1'b0;
    model = '0;
    $display("txn reset checked");
  endtask

  task automatic test_plain_commit();
    obs_t got, want;
    drive_wr(32'hBFC0_0010, 5'd5, 4'hF, 32'h0000_1234, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL plain_commit got=%h want=%h", got, want); end
    checks++;
    if (rf_we !== 4'hF || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234 || pipe_flush !== 1'b0) begin
      failures++;
      $display("FAIL plain_values we=%h waddr=%0d wdata=%h flush=%b want F/5/1234/0", rf_we, rf_waddr, rf_wdata, pipe_flush);
    end
    $display("txn plain commit pc=bfc00010");
  endtask

  task automatic test_exception();
    obs_t got, want;
    drive_wr(32'h8000_0104, 5'd7, 4'hF, 32'h5555_0000, 1'b1, 8'h60, {5'd4, 1'b1}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'hDEAD_0000);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL exception got=%h want=%h", got, want); end
    checks++;
    if (ex_commit !== 1'b1 || ex_epc !== 32'h8000_0100 || ex_bd !== 1'b1 || ex_code !== 5'd4 ||
        rf_we !== 4'd0 || cp0_we !== 1'b0 || pipe_flush !== 1'b1) begin
      failures++;
      $display("FAIL exc_delay_slot commit=%b epc=%h bd=%b code=%0d rfwe=%h cp0we=%b flush=%b want 1/80000100/1/4/0/0/1",
               ex_commit, ex_epc, ex_bd, ex_code, rf_we, cp0_we, pipe_flush);
    end
    $display("txn exception in delay slot pc=80000104");
  endtask

  task automatic test_cache_op();
    obs_t got, want;
    int   req_cycles;
    bit   hold_ok, stable_ok;
    drive_wr(32'h8000_2000, 5'd0, 4'd0, 32'd0, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 5'h01, 32'h1FC0_0000, 1'b1, 32'd0);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL cache_start got=%h want=%h", got, want); end
    req_cycles = cache_req ? 1 : 0;
    hold_ok = wr_hold; stable_ok = 1'b1;
    // Ack arrives after three full cycles of request.
    repeat (3) begin
      tick();
      if (cache_req) req_cycles++;
      if (!wr_hold) hold_ok = 1'b0;
      if (cache_req_op !== 5'h01 || cache_req_addr !== 32'h1FC0_0000) stable_ok = 1'b0;
    end
    cache_ack = 1'b1; tick(); cache_ack = 1'b0;
    if (cache_req) req_cycles++;
    if (!wr_hold) hold_ok = 1'b0;
    tick();
    if (cache_req) req_cycles++;
    if (!wr_hold) hold_ok = 1'b0;
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    checks++;
    if (req_cycles != 4) begin failures++; $display("FAIL cache_req_len got=%0d want=4", req_cycles); end
    checks++;
    if (!hold_ok || !stable_ok) begin failures++; $display("FAIL cache_hold_stable hold_ok=%b stable_ok=%b want 1/1", hold_ok, stable_ok); end
    checks++;
    if (pipe_flush !== 1'b1 || refetch_pc !== 32'h8000_2004 || wr_hold !== 1'b0 || cache_req !== 1'b0) begin
      failures++;
      $display("FAIL cache_flush flush=%b rpc=%h hold=%b req=%b want 1/80002004/0/0", pipe_flush, refetch_pc, wr_hold, cache_req);
    end
    model = clear_strobes(model);
    model.refetch_pc = 32'h8000_2004;
    exp_q.push_back(model);
    tick();
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL cache_after_flush got=%h want=%h", got, want); end
    $display("txn cache op 01 paddr=1fc00000 req_cycles=%0d", req_cycles);
  endtask

  task automatic test_ack_done_same();
    obs_t got, want;
    drive_wr(32'h8000_3000, 5'd0, 4'd0, 32'd0, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 5'h02, 32'h0000_1000, 1'b0, 32'd0);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL ackdone_start got=%h want=%h", got, want); end
    cache_ack = 1'b1; cache_done = 1'b1; tick(); cache_ack = 1'b0; cache_done = 1'b0;
    checks++;
    if (cache_req !== 1'b0 || wr_hold !== 1'b1) begin
      failures++; $display("FAIL ackdone_cwait req=%b hold=%b want 0/1", cache_req, wr_hold);
    end
    tick();
    checks++;
    if (wr_hold !== 1'b1 || pipe_flush !== 1'b0) begin
      failures++; $display("FAIL ackdone_ignored hold=%b flush=%b want 1/0", wr_hold, pipe_flush);
    end
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    checks++;
    if (wr_hold !== 1'b0 || pipe_flush !== 1'b0 || cache_req !== 1'b0) begin
      failures++; $display("FAIL ackdone_finish hold=%b flush=%b req=%b want 0/0/0", wr_hold, pipe_flush, cache_req);
    end
    model = clear_strobes(model);
    $display("txn cache op 02 with ack+done together");
  endtask

  task automatic test_exc_with_cache();
    obs_t got, want;
    bit   req_seen;
    drive_wr(32'h8000_4000, 5'd3, 4'hF, 32'h1, 1'b0, 8'd0, {5'd8, 1'b1}, 1'b0, 1'b0, 5'h01, 32'h0000_2000, 1'b1, 32'h0000_4000);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL exc_cache got=%h want=%h", got, want); end
    req_seen = cache_req;
    repeat (4) begin tick(); if (cache_req || wr_hold) req_seen = 1'b1; end
    checks++;
    if (req_seen !== 1'b0) begin failures++; $display("FAIL exc_cache_noreq seen=%b want 0", req_seen); end
    model = clear_strobes(model);
    $display("txn exception plus cache op pc=80004000");
  endtask

  task automatic test_reset_cwait();
    obs_t got, want;
    drive_wr(32'h8000_5000, 5'd0, 4'd0, 32'd0, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 5'h01, 32'h0000_3000, 1'b1, 32'd0);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL rst_cwait_start got=%h want=%h", got, want); end
    cache_ack = 1'b1; tick(); cache_ack = 1'b0;
    checks++;
    if (wr_hold !== 1'b1 || cache_req !== 1'b0) begin
      failures++; $display("FAIL rst_in_cwait hold=%b req=%b want 1/0", wr_hold, cache_req);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    got = capture();
    checks++;
    if (got !== '0) begin failures++; $display("FAIL rst_cwait_cleared got=%h want 0", got); end
    model = '0;
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    checks++;
    if (pipe_flush !== 1'b0 || wr_hold !== 1'b0 || cache_req !== 1'b0) begin
      failures++; $display("FAIL rst_cwait_discard flush=%b hold=%b req=%b want 0/0/0", pipe_flush, wr_hold, cache_req);
    end
    $display("txn reset during cwait");
  endtask

  task automatic test_refetch_wrap();
    obs_t got, want;
    drive_wr(32'hFFFF_FFFC, 5'd3, 4'h3, 32'hAAAA_5555, 1'b0, 8'd0, 6'd0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 32'd0);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (got !== want) begin failures++; $display("FAIL refetch_wrap got=%h want=%h", got, want); end
    checks++;
    if (refetch_pc !== 32'h0000_0000 || pipe_flush !== 1'b1 || rf_we !== 4'h3) begin
      failures++; $display("FAIL refetch_values rpc=%h flush=%b we=%h want 0/1/3", refetch_pc, pipe_flush, rf_we);
    end
    $display("txn inst refetch pc=fffffffc");
  endtask

  task automatic test_reg_zero_and_idle();
    obs_t got, want;
    drive_wr(32'h8000_6000, 5'd0, 4'hF, 32'h0BAD_0BAD, 1'b1, 8'h60, 6'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick(); wr_valid = 1'b0;
    want = exp_q.pop_front(); got = capture();
    checks++;
    if (rf_we !== 4'd0 || cp0_we !== 1'b1 || cp0_waddr !== 8'h60 || cp0_wdata !== 32'h0BAD_0BAD) begin
      failures++; $display("FAIL reg_zero we=%h cp0we=%b cp0addr=%h cp0data=%h want 0/1/60/0bad0bad", rf_we, cp0_we, cp0_waddr, cp0_wdata);
    end
    checks++;
    if (got !== want) begin failures++; $display("FAIL reg_zero_img got=%h want=%h", got, want); end
    for (int i = 0; i < 2; i++) begin
      model = clear_strobes(model);
      exp_q.push_back(model);
      tick();
      want = exp_q.pop_front(); got = capture();
      checks++;
      if (got !== want) begin failures++; $display("FAIL idle_hold%0d got=%h want=%h", i, got, want); end
    end
    $display("txn write to r0 then idle");
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    for (int i = 0; i < 24; i++) begin
      int          kind = $urandom_range(0, 4);
      logic [31:0] pc = $urandom;
      logic [5:0]  exinfo = (kind == 0) ? {5'($urandom_range(0, 31)), 1'b1} : 6'd0;
      drive_wr(pc, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), exinfo,
               1'($urandom_range(0, 1)), (kind == 1), 5'd0, 32'd0, 1'b0, $urandom);
      tick();
      want = exp_q.pop_front(); got = capture();
      checks++;
      if (got !== want) begin failures++; $display("FAIL b2b%0d got=%h want=%h", i, got, want); end
      $display("txn b2b %0d kind=%0d pc=%h", i, kind, pc);
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_plain_commit();
    test_exception();
    test_cache_op();
    test_ack_done_same();
    test_exc_with_cache();
    test_refetch_wrap();
    test_reg_zero_and_idle();
    test_back_to_back();
    test_reset_cwait();
    test_plain_commit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
